result_drain: RTL and testbench

//  - Downstream of the search core. On is_finish, scans entries 0..num_entries_i-1 of regfile_InexRecur/regfile_state over their random-read ports.
//  - Keeps entries whose state word marks a completed hit with a non-empty SA interval (k <= l).
//  - Streams {addr,k,l} out on a valid/ready interface through a small FIFO.
//  - Reports hit count and done. Top grants it the regfile random-read ports while busy_o=1.

---
 rtl/result_drain_pkg.sv | 38 +++
 rtl/result_fifo.sv | 60 ++++++
 rtl/result_drain.sv | 163 ++++++++++++++++
 tb/tb_result_drain.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_drain_pkg.sv
// rtl/result_drain_pkg.sv - shared field offsets, FSM encoding and helpers for result_drain
// Purpose: one place for the InexRecur word layout, the state word bit positions,
//          default sizing and the drain FSM encoding, so the top and the bench agree.
// Ports:   none (package).
package result_drain_pkg;

  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_FIFO_DEPTH = 4;

  // InexRecur word: {i[31:24], z[23:16], k[15:8], l[7:0]}
  localparam int I_MSB = 31;
  localparam int I_LSB = 24;
  localparam int Z_MSB = 23;
  localparam int Z_LSB = 16;
  localparam int K_MSB = 15;
  localparam int K_LSB = 8;
  localparam int L_MSB = 7;
  localparam int L_LSB = 0;

  // State word: [17]=entry valid, [16]=hit, [4:0]=position
  localparam int ST_VALID   = 17;
  localparam int ST_HIT     = 16;
  localparam int ST_POS_MSB = 4;
  localparam int ST_POS_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } drain_state_e;

  // An SA interval is non-empty when its lower bound does not exceed the upper bound.
  function automatic logic interval_ok(input logic [7:0] k, input logic [7:0] l);
    return k <= l;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous result FIFO holding {addr,k,l} records
// Purpose: small power-of-two FIFO between the filter and the result stream.
// Ports:   clk, rst_n      clock, async active-low reset (empties FIFO, zeroes storage)
//          push_i, data_i  write request and record (ignored when full)
//          pop_i, data_o   read request (ignored when empty) and head record
//          full_o, empty_o, count_o  occupancy status
module result_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/result_drain.sv
// rtl/result_drain.sv - post-search scan of the regfiles, filtering hits into a result stream
// Purpose: on a finish edge, read entries 0..num_entries-1 of InexRecur/state, keep valid
//          hits with k <= l, and stream {addr,k,l} out through result_fifo.
// Ports:   clk, rst_n                      clock, async active-low reset
//          is_finish_i, num_entries_i      scan trigger (rising edge) and entry count
//          re_reg_*_ran_o, r_reg_*_addr_o  paired random-read enable/address (1-cycle latency)
//          InexRecur_data_i, state_data_i  read data returned the cycle after a read
//          res_valid_o/res_ready_i, res_addr_o/res_k_o/res_l_o  result stream
//          hit_count_o, busy_o, done_o     status: pushes this scan, port ownership, end pulse
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_finish_i,
  input  logic [ADDR_W:0]   num_entries_i,
  output logic              re_reg_InexRecur_ran_o,
  output logic [ADDR_W-1:0] r_reg_InexRecur_addr_o,
  input  logic [31:0]       InexRecur_data_i,
  output logic              re_reg_state_ran_o,
  output logic [ADDR_W-1:0] r_reg_state_addr_o,
  input  logic [17:0]       state_data_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic [7:0]        res_k_o,
  output logic [7:0]        res_l_o,
  output logic [ADDR_W:0]   hit_count_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CW    = ADDR_W + 1;
  localparam int RES_W = ADDR_W + 16;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  drain_state_e      state_q, state_d;
  logic              fin_q;
  logic [CW-1:0]     num_q, num_d;
  logic [CW-1:0]     nxt_q, nxt_d;      // next address to issue; 13 bits so 4096 never wraps
  logic              re_q, re_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              chk_q;             // read data is on the inputs this cycle
  logic [ADDR_W-1:0] chk_addr_q;
  logic [CW-1:0]     hit_q, hit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]        k_w, l_w;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, count_nx;
  logic [RES_W-1:0]  head;
  logic              unused_fields;

  assign k_w  = InexRecur_data_i[K_MSB:K_LSB];
  assign l_w  = InexRecur_data_i[L_MSB:L_LSB];
  assign push = chk_q && state_data_i[ST_VALID] && state_data_i[ST_HIT]
                && interval_ok(k_w, l_w) && !fifo_full;
  assign pop  = res_valid_o && res_ready_i;
  assign count_nx = fifo_count + CNT_W'(push) - CNT_W'(pop);

  assign unused_fields = ^{InexRecur_data_i[I_MSB:I_LSB], InexRecur_data_i[Z_MSB:Z_LSB],
                           state_data_i[ST_HIT-1:ST_POS_MSB+1],
                           state_data_i[ST_POS_MSB:ST_POS_LSB]};

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    nxt_d   = nxt_q;
    raddr_d = raddr_q;
    hit_d   = push ? hit_q + CW'(1) : hit_q;
    done_d  = 1'b0;
    re_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_finish_i && !fin_q) begin
          state_d = S_SCAN;
          num_d   = num_entries_i;
          nxt_d   = '0;
          hit_d   = '0;
        end
      end
      S_SCAN:  if (nxt_q == num_q && !re_q && !chk_q) state_d = S_FLUSH;
      S_FLUSH: begin
        if (fifo_empty) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  if (!is_finish_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Read enable is registered, so the credit test looks one cycle ahead: the FIFO
    // occupancy after this edge plus the read whose data lands next cycle.
    if (state_d == S_SCAN && nxt_d < num_d
        && (int'(count_nx) + int'(re_q)) < FIFO_DEPTH) begin
      re_d    = 1'b1;
      raddr_d = nxt_d[ADDR_W-1:0];
      nxt_d   = nxt_d + CW'(1);
    end
    busy_d = (state_d == S_SCAN) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fin_q      <= 1'b0;
      num_q      <= '0;
      nxt_q      <= '0;
      re_q       <= 1'b0;
      raddr_q    <= '0;
      chk_q      <= 1'b0;
      chk_addr_q <= '0;
      hit_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fin_q      <= is_finish_i;
      num_q      <= num_d;
      nxt_q      <= nxt_d;
      re_q       <= re_d;
      raddr_q    <= raddr_d;
      chk_q      <= re_q;
      chk_addr_q <= raddr_q;
      hit_q      <= hit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({chk_addr_q, k_w, l_w}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign re_reg_InexRecur_ran_o = re_q;
  assign re_reg_state_ran_o     = re_q;
  assign r_reg_InexRecur_addr_o = raddr_q;
  assign r_reg_state_addr_o     = raddr_q;
  assign res_valid_o            = !fifo_empty;
  assign res_addr_o             = head[RES_W-1:16];
  assign res_k_o                = head[15:8];
  assign res_l_o                = head[7:0];
  assign hit_count_o            = hit_q;
  assign busy_o                 = busy_q;
  assign done_o                 = done_q;

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - self-checking bench for result_drain
module tb_result_drain;

  localparam int F_BASIC = 0, F_ALLHIT = 1, F_INVALID = 2, F_RANDOM = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_finish_i;
  logic [12:0] num_entries_i;
  logic        re_i, re_s;
  logic [11:0] a_i, a_s;
  logic [31:0] inex_data;
  logic [17:0] st_data;
  logic        res_valid_o, res_ready_i;
  logic [11:0] res_addr_o;
  logic [7:0]  res_k_o, res_l_o;
  logic [12:0] hit_count_o;
  logic        busy_o, done_o;

  int checks = 0;
  int failures = 0;
  int ready_pct = 100;
  int done_cnt = 0;

  logic [31:0] inex_mem [4096];
  logic [17:0] st_mem   [4096];
  logic [27:0] exp_q[$];
  logic [27:0] got_q[$];
  int          rd_q[$];

  logic        stall_prev = 1'b0;
  logic [27:0] held;

  typedef struct packed {
    int n;
    int fill;
    int rp;
    int exp_hits;   // -1: take the count from the reference model
    int lat_min;
    int lat_max;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  result_drain dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .is_finish_i            (is_finish_i),
    .num_entries_i          (num_entries_i),
    .re_reg_InexRecur_ran_o (re_i),
    .r_reg_InexRecur_addr_o (a_i),
    .InexRecur_data_i       (inex_data),
    .re_reg_state_ran_o     (re_s),
    .r_reg_state_addr_o     (a_s),
    .state_data_i           (st_data),
    .res_valid_o            (res_valid_o),
    .res_ready_i            (res_ready_i),
    .res_addr_o             (res_addr_o),
    .res_k_o                (res_k_o),
    .res_l_o                (res_l_o),
    .hit_count_o            (hit_count_o),
    .busy_o                 (busy_o),
    .done_o                 (done_o)
  );

  // Regfile model: data one cycle after the read, garbage otherwise.
  always @(posedge clk) begin
    inex_data <= re_i ? inex_mem[a_i] : $urandom();
    st_data   <= re_s ? st_mem[a_s] : 18'($urandom());
  end

  initial begin
    res_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1 res_ready_i = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (re_i || re_s) begin
        check("re_pair", {re_i, a_i}, {re_s, a_s});
        if (re_i) rd_q.push_back(int'(a_i));
      end
      if (stall_prev) check("res_stable", {res_valid_o, res_addr_o, res_k_o, res_l_o}, {1'b1, held});
      if (res_valid_o && res_ready_i) got_q.push_back({res_addr_o, res_k_o, res_l_o});
      stall_prev = res_valid_o && !res_ready_i;
      held = {res_addr_o, res_k_o, res_l_o};
      if (done_o) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic fill_mem(input int mode);
    logic [7:0] k, l;
    logic v, h;
    for (int a = 0; a < 4096; a++) begin
      k = 8'($urandom_range(0, 15));
      l = 8'($urandom_range(0, 15));
      v = 1'b0;
      h = 1'($urandom());
      if (mode == F_ALLHIT) begin
        k = 8'($urandom_range(0, 127));
        l = k + 8'($urandom_range(0, 127));
        v = 1'b1;
        h = 1'b1;
      end else if (mode == F_RANDOM) begin
        v = ($urandom_range(0, 3) != 0);
        h = ($urandom_range(0, 2) != 0);
      end
      inex_mem[a] = {8'($urandom()), 8'($urandom()), k, l};
      st_mem[a]   = {v, h, 11'($urandom()), 5'($urandom())};
    end
    if (mode == F_BASIC) begin
      inex_mem[0] = {16'h1234, 8'd1, 8'd2}; st_mem[0] = {2'b10, 16'h0003};
      inex_mem[1] = {16'h5678, 8'd3, 8'd7}; st_mem[1] = {2'b11, 16'h0001};
      inex_mem[2] = {16'h9abc, 8'd9, 8'd4}; st_mem[2] = {2'b11, 16'h0002};
      inex_mem[3] = {16'hdef0, 8'd0, 8'd0}; st_mem[3] = {2'b11, 16'h0004};
    end
  endtask

  // Reference: entries in address order that are valid, hit and have k <= l.
  task automatic build_expected(input int n);
    exp_q.delete();
    for (int a = 0; a < n; a++)
      if (st_mem[a][17] && st_mem[a][16] && inex_mem[a][15:8] <= inex_mem[a][7:0])
        exp_q.push_back({12'(a), inex_mem[a][15:8], inex_mem[a][7:0]});
  endtask

  task automatic finish_checks(input int n, input int exp_hits, input int tag);
    int bad;
    int req_hits;
    bad = -1;
    for (int i = 0; i < exp_q.size() && bad < 0; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL results[%0d] actual count=%0d required count=%0d first bad idx=%0d",
               tag, got_q.size(), exp_q.size(), bad);
    end
    bad = (rd_q.size() == n) ? -1 : 0;
    for (int i = 0; i < rd_q.size() && bad < 0; i++) if (rd_q[i] != i) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL read_seq[%0d] actual reads=%0d required reads=%0d first bad idx=%0d",
               tag, rd_q.size(), n, bad);
    end
    req_hits = (exp_hits >= 0) ? exp_hits : exp_q.size();
    check($sformatf("hit_count[%0d]", tag), hit_count_o, req_hits);
    check($sformatf("done_pulses[%0d]", tag), done_cnt, 1);
    check($sformatf("idle_after[%0d]", tag), {busy_o, res_valid_o}, 0);
  endtask

  task automatic start_scan(input int n);
    #1;
    got_q.delete();
    rd_q.delete();
    done_cnt = 0;
    num_entries_i = 13'(n);
    is_finish_i = 1'b1;
    @(posedge clk);
    #1 is_finish_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      if (done_o) break;
      cyc++;
    end
  endtask

  task automatic run_scan(input int n, input int rp, input int exp_hits,
                          input int lat_min, input int lat_max, input int tag);
    int cyc;
    ready_pct = rp;
    build_expected(n);
    repeat (2) @(posedge clk);
    start_scan(n);
    wait_done(lat_max + 50, cyc);
    check($sformatf("timeout[%0d]", tag), cyc >= lat_max + 50, 0);
    check_range($sformatf("done_latency[%0d]", tag), cyc, lat_min, lat_max);
    repeat (4) @(negedge clk);
    finish_checks(n, exp_hits, tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    rst_n = 1'b0;
    is_finish_i = 1'b0;
    num_entries_i = '0;
    fill_mem(F_INVALID);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("reset_ctrl", {re_i, re_s, res_valid_o, busy_o, done_o, hit_count_o}, 0);
    check("reset_data", {a_i, a_s, res_addr_o, res_k_o, res_l_o}, 0);

    vecs[0] = '{n: 4,    fill: F_BASIC,   rp: 100, exp_hits: 2,  lat_min: 5,    lat_max: 8};
    vecs[1] = '{n: 0,    fill: F_RANDOM,  rp: 100, exp_hits: 0,  lat_min: 2,    lat_max: 2};
    vecs[2] = '{n: 8,    fill: F_ALLHIT,  rp: 100, exp_hits: 8,  lat_min: 9,    lat_max: 12};
    vecs[3] = '{n: 16,   fill: F_ALLHIT,  rp: 50,  exp_hits: 16, lat_min: 17,   lat_max: 400};
    vecs[4] = '{n: 30,   fill: F_RANDOM,  rp: 70,  exp_hits: -1, lat_min: 31,   lat_max: 600};
    vecs[5] = '{n: 4096, fill: F_INVALID, rp: 100, exp_hits: 0,  lat_min: 4090, lat_max: 4110};
    vecs[6] = '{n: 1,    fill: F_ALLHIT,  rp: 100, exp_hits: 1,  lat_min: 2,    lat_max: 5};

    for (int v = 0; v < 7; v++) begin
      fill_mem(vecs[v].fill);
      run_scan(vecs[v].n, vecs[v].rp, vecs[v].exp_hits, vecs[v].lat_min, vecs[v].lat_max, v);
    end

    // Backpressure: consumer stalled, finish re-toggled while busy.
    fill_mem(F_ALLHIT);
    build_expected(8);
    ready_pct = 0;
    repeat (3) @(posedge clk);
    start_scan(8);
    repeat (5) @(posedge clk);
    #1 is_finish_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 is_finish_i = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("bp_reads_issued", rd_q.size(), 4);
    check("bp_no_output", got_q.size(), 0);
    check("bp_busy", busy_o, 1);
    ready_pct = 100;
    wait_done(100, cyc);
    check("bp_timeout", cyc >= 100, 0);
    repeat (6) @(negedge clk);
    finish_checks(8, 8, 50);

    // Reset in the middle of a scan.
    fill_mem(F_ALLHIT);
    ready_pct = 100;
    repeat (2) @(posedge clk);
    start_scan(64);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (re_i && a_i == 12'd10) break;
      cyc++;
    end
    check("rst_reach_addr10", cyc < 200, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_ctrl_zero", {re_i, re_s, busy_o, done_o, res_valid_o}, 0);
    check("rst_data_zero", {a_i, a_s, res_addr_o, res_k_o, res_l_o}, 0);
    check("rst_hits_zero", hit_count_o, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_done", done_cnt, 0);
    run_scan(12, 100, 12, 13, 16, 60);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 48);
      fill_mem(F_RANDOM);
      run_scan(n, $urandom_range(20, 100), -1, n + 1, 30 * n + 50, 100 + r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
